// File: rtl/ghost_pkg.sv
// Shared definitions for the OTP-domain clocking blocks.
// Holds the PLL sequencer state encodings and default timing constants.
package ghost_pkg;

    typedef enum logic [2:0] {
        PLL_ST_RST_PLL   = 3'd0,
        PLL_ST_WAIT_LOCK = 3'd1,
        PLL_ST_STABLE    = 3'd2,
        PLL_ST_READY     = 3'd3,
        PLL_ST_FAIL      = 3'd4
    } pll_st_e;

    localparam int PLL_RST_CYCLES_DEF    = 16;
    localparam int PLL_STABLE_CYCLES_DEF = 1024;
    localparam int PLL_TIMEOUT_DEF       = 65536;
    localparam int PLL_MAX_RETRIES_DEF   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous reset to 0.
// Ports: clk, rst (async, active high), d_i (async input), q_o (synchronised).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// Bring-up sequencer for the OTP-domain rPLL: reset pulse, lock wait with
// bounded retries, lock qualification, ready flag, relock on loss/request.
// Ports: clkin, reset (async, active high), pll_lock_i (async), relock_req_i,
//        pll_reset_o, pll_ready_o, pll_fail_o, unlock_evt_o, retry_cnt_o[1:0].
module pll_lock_ctrl
    import ghost_pkg::*;
#(
    parameter int RST_CYCLES          = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE_CYCLES  = PLL_STABLE_CYCLES_DEF,
    parameter int LOCK_TIMEOUT_CYCLES = PLL_TIMEOUT_DEF,
    parameter int MAX_RETRIES         = PLL_MAX_RETRIES_DEF
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       pll_ready_o,
    output logic       pll_fail_o,
    output logic       unlock_evt_o,
    output logic [1:0] retry_cnt_o
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RTY_LIM  = 2'(MAX_RETRIES);

    logic lock_s;

    pll_st_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    retry_q, retry_d;
    logic          reset_q, reset_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          unlock_q, unlock_d;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d_i (pll_lock_i),
        .q_o (lock_s)
    );

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q  <= PLL_ST_RST_PLL;
            cnt_q    <= '0;
            retry_q  <= 2'd0;
            reset_q  <= 1'b1;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
            unlock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            reset_q  <= reset_d;
            ready_q  <= ready_d;
            fail_q   <= fail_d;
            unlock_q <= unlock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;

        unique case (state_q)
            PLL_ST_RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = PLL_ST_WAIT_LOCK;
                end
            end
            PLL_ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = PLL_ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RTY_LIM) begin
                        state_d = PLL_ST_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = PLL_ST_RST_PLL;
                    end
                end
            end
            PLL_ST_STABLE: begin
                if (!lock_s) begin
                    state_d = PLL_ST_WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = PLL_ST_READY;
                    retry_d = 2'd0;
                end
            end
            PLL_ST_READY: begin
                if (!lock_s) begin
                    state_d = PLL_ST_RST_PLL;
                end
            end
            PLL_ST_FAIL: begin
                state_d = PLL_ST_FAIL;
            end
            default: begin
                state_d = PLL_ST_RST_PLL;
            end
        endcase

        // A request overrides every transition above, including a
        // coincident timeout, so the retry count is not bumped then.
        if (relock_req_i) begin
            state_d = PLL_ST_RST_PLL;
            retry_d = (state_q == PLL_ST_FAIL) ? 2'd0 : retry_q;
        end

        // READY and FAIL have no timed exit; park the counter there.
        if (state_d != state_q || relock_req_i ||
            state_q == PLL_ST_READY || state_q == PLL_ST_FAIL) begin
            cnt_d = '0;
        end
    end

    // Outputs follow the current state one edge late, so ready has
    // already dropped by the time the reset pulse becomes visible.
    always_comb begin
        reset_d  = (state_q == PLL_ST_RST_PLL) ||
                   (state_q == PLL_ST_FAIL);
        ready_d  = (state_q == PLL_ST_READY);
        fail_d   = (state_q == PLL_ST_FAIL);
        unlock_d = (state_q == PLL_ST_READY) && !lock_s;
    end

    assign pll_reset_o  = reset_q;
    assign pll_ready_o  = ready_q;
    assign pll_fail_o   = fail_q;
    assign unlock_evt_o = unlock_q;
    assign retry_cnt_o  = retry_q;

endmodule
